// File: rtl/mem_bridge.sv
// mem_bridge: turns the core's single-cycle load/store strobes into req/ack
// transactions on a multi-cycle memory bus. Word alignment is checked before a
// transaction starts. A bus that stays silent is aborted after TIMEOUT busy
// cycles. Any misalignment, timeout or load/store conflict sets a sticky err flag.
module mem_bridge #(
    parameter int W       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         stall,
    output logic         bus_req,
    output logic         bus_we,
    output logic [W-1:0] bus_addr,
    output logic [W-1:0] bus_wdata,
    input  logic         bus_ack,
    input  logic [W-1:0] bus_rdata,
    output logic         err
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cnt_r;
    logic            bus_req_r;
    logic            bus_we_r;
    logic [W-1:0]    bus_addr_r;
    logic [W-1:0]    bus_wdata_r;
    logic [W-1:0]    l_data_r;
    logic            err_r;

    logic            req_s;
    logic            conflict_s;
    logic [W-1:0]    sel_addr_s;
    logic            aligned_s;
    logic            last_s;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

    // Request decode: a store takes priority over a simultaneous load.
    always_comb begin
        req_s      = load_en | store_en;
        conflict_s = load_en & store_en;
        if (store_en) begin
            sel_addr_s = s_addr;
        end else begin
            sel_addr_s = l_addr;
        end
        aligned_s  = is_word_aligned(sel_addr_s[1:0]);
        last_s     = (cnt_r == CW'(TIMEOUT - 1));
    end

    // Stall freezes the core. It is held low while reset is asserted, so the core
    // is never frozen by a bridge that is being reset.
    always_comb begin
        stall = rst & (((state_r == IDLE) & req_s) | (state_r == BUSY));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. A misaligned request skips the bus and goes straight to DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (aligned_s) begin
                        next_state_s = BUSY;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus_ack || last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Bus-side registers, load data, timeout counter and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {W{1'b0}};
            bus_wdata_r <= {W{1'b0}};
            l_data_r    <= {W{1'b0}};
            err_r       <= 1'b0;
            cnt_r       <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        bus_we_r    <= store_en;
                        bus_addr_r  <= {sel_addr_s[W-1:2], 2'b00};
                        bus_wdata_r <= s_data;
                        cnt_r       <= {CW{1'b0}};
                        if (conflict_s) begin
                            err_r <= 1'b1;
                        end
                        if (aligned_s) begin
                            bus_req_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                            // A store leaves the load result alone, even on an error.
                            if (!store_en) begin
                                l_data_r <= {W{1'b0}};
                            end
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        // An ack on the final cycle still wins over the timeout.
                        bus_req_r <= 1'b0;
                        if (!bus_we_r) begin
                            l_data_r <= bus_rdata;
                        end
                    end else if (last_s) begin
                        bus_req_r <= 1'b0;
                        err_r     <= 1'b1;
                        if (!bus_we_r) begin
                            l_data_r <= W'(32'hDEADBEEF);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    bus_req_r <= 1'b0;
                    cnt_r     <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign l_data    = l_data_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed transactions with a queue-based scoreboard. The stimulus
// pushes the expected outcome of each transaction, and a negedge monitor checks the
// bus fields on every request cycle and the result in each DONE cycle.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] l_addr = 32'h0;
    logic [31:0] l_data;
    logic        store_en = 1'b0;
    logic [31:0] s_addr = 32'h0;
    logic [31:0] s_data = 32'h0;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ldata;
        logic        err;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t exp_q[$];

    int ack_at = 0;   // BUSY cycle (1-based) on which the responder acks; 0 = never

    mem_bridge #(.W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
        .store_en(store_en), .s_addr(s_addr), .s_data(s_data),
        .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: counts request cycles and acks on the requested one.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req) begin
                n++;
                bus_ack = (ack_at != 0) && (n == ack_at);
            end else begin
                n = 0;
                bus_ack = 1'b0;
            end
        end
    end

    // Monitor: checks bus fields while bus_req is high and checks the result in DONE.
    initial begin
        int   stall_cnt;
        int   req_cnt;
        logic prev_stall;
        exp_t e;
        stall_cnt  = 0;
        req_cnt    = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_cnt  = 0;
                req_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (bus_req) begin
                    req_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("bus_we", {31'd0, bus_we}, {31'd0, exp_q[0].we});
                        chk("bus_addr", bus_addr, exp_q[0].addr);
                        if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].wdata);
                    end
                end
                if (stall) begin
                    stall_cnt++;
                end else if (prev_stall) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("l_data", l_data, e.ldata);
                        chk("err", {31'd0, err}, {31'd0, e.err});
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                        chk("req_cycles", 32'(req_cnt), 32'(e.reqs));
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
                prev_stall = stall;
            end
        end
    end

    // Launch one core request and hold it until the bridge reaches DONE.
    task automatic run_op(input logic ld, input logic st, input logic [31:0] la,
                          input logic [31:0] sa, input logic [31:0] sd, input int ack,
                          input logic [31:0] rd, input exp_t e);
        bit finished;
        @(posedge clk);
        #2;
        exp_q.push_back(e);
        ack_at    = ack;
        bus_rdata = rd;
        load_en   = ld;
        store_en  = st;
        l_addr    = la;
        s_addr    = sa;
        s_data    = sd;
        finished  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (!stall) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) chk("done_timeout", 32'd0, 32'd1);
        load_en  = 1'b0;
        store_en = 1'b0;
    endtask

    function automatic exp_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] ld, input logic er, input int st, input int rq);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.ldata = ld;
        e.err = er; e.stalls = st; e.reqs = rq;
        return e;
    endfunction

    initial begin
        // Reset state.
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_l_data", l_data, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Aligned load, ack in the first BUSY cycle.
        run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1, 32'hCAFEF00D,
               mk(1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1));
        // Aligned store, ack on the third BUSY cycle; l_data unchanged.
        run_op(1'b0, 1'b1, 32'h0, 32'h204, 32'h12345678, 3, 32'hFFFFFFFF,
               mk(1'b1, 32'h204, 32'h12345678, 32'hCAFEF00D, 1'b0, 4, 3));
        // Ack on the final cycle before timeout: normal completion.
        run_op(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 16, 32'hA5A50001,
               mk(1'b0, 32'h300, 32'h0, 32'hA5A50001, 1'b0, 17, 16));
        // Misaligned store: no bus cycle, err set, l_data untouched.
        run_op(1'b0, 1'b1, 32'h0, 32'h206, 32'h55555555, 1, 32'h0,
               mk(1'b1, 32'h204, 32'h55555555, 32'hA5A50001, 1'b1, 1, 0));

        // Reset in the middle of a BUSY load.
        @(posedge clk);
        #2;
        exp_q.push_back(mk(1'b0, 32'h400, 32'h0, 32'h0, 1'b0, 0, 0));
        ack_at  = 0;
        load_en = 1'b1;
        l_addr  = 32'h400;
        repeat (5) @(posedge clk);
        #2;
        chk("busy_before_rst", {31'd0, bus_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_l_data", l_data, 32'h0);
        exp_q.delete();
        load_en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Load with ack in the second BUSY cycle.
        run_op(1'b1, 1'b0, 32'h104, 32'h0, 32'h0, 2, 32'h13579BDF,
               mk(1'b0, 32'h104, 32'h0, 32'h13579BDF, 1'b0, 3, 2));
        // Misaligned load: l_data cleared, err set, single stall cycle.
        run_op(1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 1, 32'h0,
               mk(1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0));
        // Load with no ack: abort after 16 request cycles.
        run_op(1'b1, 1'b0, 32'h304, 32'h0, 32'h0, 0, 32'h0,
               mk(1'b0, 32'h304, 32'h0, 32'hDEADBEEF, 1'b1, 17, 16));

        // Plain reset to clear the sticky error.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst2_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Load and store together: only the write runs, err set.
        run_op(1'b1, 1'b1, 32'h500, 32'h600, 32'h0BADF00D, 2, 32'h77777777,
               mk(1'b1, 32'h600, 32'h0BADF00D, 32'h0, 1'b1, 3, 2));

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_bus_req", {31'd0, bus_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
